div_issue_ctrl: RTL and testbench

//  Execute-stage front end for the iterative divider (RV32M DIV/DIVU/REM/REMU).
//  - Accepts one divide request from EX and issues it to the divider over the divider_if signals.
//  - Stalls EX until the result is ready, then selects the quotient or the remainder.
//  - Caches the last result so that DIV+REM on the same operands costs one divider run.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/div_result_cache.sv | 59 +++++
 rtl/div_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_div_issue_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the execute-stage divider front end.
package cpu_types_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b10
  } div_state_t;

  function automatic logic op_is_signed(input div_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_result_cache.sv
// Last divider result (q and r) tagged by {signed, a, b}; a hit lets DIV+REM share one run.
module div_result_cache
  import cpu_types_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            load,
  input  logic            invalidate,
  input  logic            clr_fresh,
  input  logic            tag_signed,
  input  logic [XLEN-1:0] tag_a,
  input  logic [XLEN-1:0] tag_b,
  input  logic [XLEN-1:0] ld_q,
  input  logic [XLEN-1:0] ld_r,
  input  logic            cmp_signed,
  input  logic [XLEN-1:0] cmp_a,
  input  logic [XLEN-1:0] cmp_b,
  output logic            hit,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r
);

  logic            res_vld;
  logic            fresh;
  logic            t_signed;
  logic [XLEN-1:0] t_a;
  logic [XLEN-1:0] t_b;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      res_vld  <= 1'b0;
      fresh    <= 1'b0;
      t_signed <= 1'b0;
      t_a      <= '0;
      t_b      <= '0;
      q        <= '0;
      r        <= '0;
    end else if (load) begin
      res_vld  <= 1'b1;
      fresh    <= 1'b1;
      t_signed <= tag_signed;
      t_a      <= tag_a;
      t_b      <= tag_b;
      q        <= ld_q;
      r        <= ld_r;
    end else begin
      if (invalidate) res_vld <= 1'b0;
      if (clr_fresh)  fresh   <= 1'b0;
    end
  end

  // Without reuse, only the single consume right after capture may hit
  assign hit = res_vld && (t_signed == cmp_signed) && (t_a == cmp_a) && (t_b == cmp_b)
               && (CACHE_EN || fresh);

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage front end for the iterative divider: issue, stall, drain on flush, result select.
module div_issue_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            req_valid,
  input  div_op_t         req_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            div_en,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  output logic            div_is_signed,
  input  logic            div_ready,
  input  logic [XLEN-1:0] div_q,
  input  logic [XLEN-1:0] div_r
);

  div_state_t      state;
  div_state_t      state_nxt;
  logic            req_live;
  logic            req_signed;
  logic            hit;
  logic            issue;
  logic            capture;
  logic            discard;
  logic            ready_ok;
  logic            clr_fresh;
  logic [XLEN-1:0] q_reg;
  logic [XLEN-1:0] r_reg;

  assign req_signed   = op_is_signed(req_op);
  assign req_live     = req_valid && !flush;
  assign result_valid = req_live && (state == IDLE) && hit;
  assign stall        = req_live && !result_valid;
  assign result       = op_is_rem(req_op) ? r_reg : q_reg;
  // div_ready still reflects the previous run during the en cycle
  assign ready_ok     = div_ready && !div_en;
  assign clr_fresh    = issue || result_valid;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    capture   = 1'b0;
    discard   = 1'b0;
    case (state)
      IDLE: begin
        if (req_live && !hit) begin
          issue     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (ready_ok) begin
          capture   = !flush;
          discard   = flush;
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (ready_ok) begin
          discard   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      div_en        <= 1'b0;
      div_a         <= '0;
      div_b         <= '0;
      div_is_signed <= 1'b0;
    end else begin
      state  <= state_nxt;
      div_en <= issue;
      if (issue) begin
        div_a         <= rs1;
        div_b         <= rs2;
        div_is_signed <= req_signed;
      end
    end
  end

  div_result_cache #(
    .XLEN     (XLEN),
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .clk        (clk),
    .nrst       (nrst),
    .load       (capture),
    .invalidate (discard),
    .clr_fresh  (clr_fresh),
    .tag_signed (div_is_signed),
    .tag_a      (div_a),
    .tag_b      (div_b),
    .ld_q       (div_q),
    .ld_r       (div_r),
    .cmp_signed (req_signed),
    .cmp_a      (rs1),
    .cmp_b      (rs2),
    .hit        (hit),
    .q          (q_reg),
    .r          (r_reg)
  );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed cases plus random ops against a request-level cache model.
module tb_div_issue_ctrl;
  import cpu_types_pkg::*;

  localparam bit CE_MAIN = 1'b1;

  logic        clk = 1'b0;
  logic        nrst;
  int          checks = 0;
  int          errors = 0;

  // main instance (reuse enabled)
  logic        req_valid, flush, stall, result_valid, div_en, div_is_signed;
  div_op_t     req_op;
  logic [31:0] rs1, rs2, result, div_a, div_b;
  logic        dv_ready;
  logic [31:0] dv_q, dv_r;
  int          dv_cnt, dv_lat;

  // second instance (reuse disabled)
  logic        nc_req_valid, nc_flush, nc_stall, nc_result_valid, nc_div_en, nc_div_is_signed;
  div_op_t     nc_req_op;
  logic [31:0] nc_rs1, nc_rs2, nc_result, nc_div_a, nc_div_b;
  logic        nc_ready;
  logic [31:0] nc_q, nc_r;
  int          nc_cnt;

  // request-level model of the cached result
  bit          m_vld, m_sgn, m_fresh;
  logic [31:0] m_a, m_b;

  always #5 clk = ~clk;

  div_issue_ctrl #(.XLEN(32), .CACHE_EN(CE_MAIN)) u_dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_op(req_op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall(stall), .result_valid(result_valid), .result(result),
    .div_en(div_en), .div_a(div_a), .div_b(div_b), .div_is_signed(div_is_signed),
    .div_ready(dv_ready), .div_q(dv_q), .div_r(dv_r));

  div_issue_ctrl #(.XLEN(32), .CACHE_EN(1'b0)) u_nc (
    .clk(clk), .nrst(nrst), .req_valid(nc_req_valid), .req_op(nc_req_op), .rs1(nc_rs1),
    .rs2(nc_rs2), .flush(nc_flush), .stall(nc_stall), .result_valid(nc_result_valid),
    .result(nc_result), .div_en(nc_div_en), .div_a(nc_div_a), .div_b(nc_div_b),
    .div_is_signed(nc_div_is_signed), .div_ready(nc_ready), .div_q(nc_q), .div_r(nc_r));

  function automatic logic [63:0] rv_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b)); r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b; r = a % b;
    end
    return {q, r};
  endfunction

  function automatic bit sgn_of(input div_op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic bit rem_of(input div_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic bit pred_hit(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
    return m_vld && (m_sgn == sgn_of(op)) && (m_a == a) && (m_b == b) && (CE_MAIN || m_fresh);
  endfunction

  // divider models: ready drops the cycle after en, returns after the set number of cycles
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dv_ready <= 1'b1; dv_cnt <= 0; dv_q <= 32'd0; dv_r <= 32'd0;
    end else if (div_en) begin
      {dv_q, dv_r} <= rv_div(div_is_signed, div_a, div_b);
      dv_ready <= 1'b0; dv_cnt <= dv_lat;
    end else if (dv_cnt > 1) begin
      dv_cnt <= dv_cnt - 1;
    end else if (dv_cnt == 1) begin
      dv_ready <= 1'b1; dv_cnt <= 0;
    end
  end

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nc_ready <= 1'b1; nc_cnt <= 0; nc_q <= 32'd0; nc_r <= 32'd0;
    end else if (nc_div_en) begin
      {nc_q, nc_r} <= rv_div(nc_div_is_signed, nc_div_a, nc_div_b);
      nc_ready <= 1'b0; nc_cnt <= 2;
    end else if (nc_cnt > 1) begin
      nc_cnt <= nc_cnt - 1;
    end else if (nc_cnt == 1) begin
      nc_ready <= 1'b1; nc_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full request without flush; a miss costs latency+3 stall cycles and one div_en.
  task automatic do_req(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input string tag);
    bit          h, got;
    logic [63:0] qr;
    logic [31:0] exp;
    int          en_n, st_n;
    h    = pred_hit(op, a, b);
    qr   = rv_div(sgn_of(op), a, b);
    exp  = rem_of(op) ? qr[31:0] : qr[63:32];
    dv_lat = lat;
    en_n = 0; st_n = 0; got = 1'b0;
    for (int c = 0; c < lat + 20 && !got; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = op; rs1 = a; rs2 = b; flush = 1'b0;
      #1;
      if (div_en) en_n++;
      if (result_valid) begin
        got = 1'b1;
        chk({tag, " result"}, 64'(result), 64'(exp));
      end else if (stall) begin
        st_n++;
      end
    end
    chk({tag, " done"}, 64'(got), 64'd1);
    chk({tag, " stalls"}, 64'(st_n), h ? 64'd0 : 64'(lat + 3));
    chk({tag, " div_en"}, 64'(en_n), h ? 64'd0 : 64'd1);
    if (!h) begin
      m_vld = 1'b1; m_sgn = sgn_of(op); m_a = a; m_b = b;
    end
    m_fresh = 1'b0;
  endtask

  // Request killed by flush k cycles after it was presented (k=0: flushed while still in IDLE).
  task automatic do_flush(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int k, input string tag);
    int en_n, rv_n, st_n;
    bit done;
    dv_lat = lat;
    en_n = 0; rv_n = 0; st_n = 0; done = 1'b0;
    for (int c = 0; c <= k; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = op; rs1 = a; rs2 = b; flush = (c == k);
      #1;
      if (div_en) en_n++;
      if (result_valid) rv_n++;
    end
    for (int c = 0; c < lat + 20 && !done; c++) begin
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      #1;
      if (div_en) en_n++;
      if (result_valid) rv_n++;
      if (stall) st_n++;
      if (dv_ready && !div_en) done = 1'b1;
    end
    @(negedge clk);
    #1;
    if (stall) st_n++;
    chk({tag, " drained"}, 64'(done), 64'd1);
    chk({tag, " no result"}, 64'(rv_n), 64'd0);
    chk({tag, " idle stall"}, 64'(st_n), 64'd0);
    chk({tag, " div_en"}, 64'(en_n), (k == 0) ? 64'd0 : 64'd1);
    if (k > 0) m_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0; flush = 1'($urandom_range(0, 1));
      req_op = div_op_t'(2'($urandom_range(0, 3))); rs1 = $urandom; rs2 = $urandom;
      #1;
      chk("idle stall", 64'(stall), 64'd0);
      chk("idle result_valid", 64'(result_valid), 64'd0);
      chk("idle div_en", 64'(div_en), 64'd0);
    end
    flush = 1'b0;
  endtask

  task automatic nc_req(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int en_n;
    bit got;
    en_n = 0; got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      nc_req_valid = 1'b1; nc_req_op = op; nc_rs1 = a; nc_rs2 = b;
      #1;
      if (nc_div_en) en_n++;
      if (nc_result_valid) begin
        got = 1'b1;
        chk({tag, " result"}, 64'(nc_result), 64'(exp));
      end
    end
    chk({tag, " done"}, 64'(got), 64'd1);
    chk({tag, " div_en"}, 64'(en_n), 64'd1);
  endtask

  initial begin
    logic [31:0] pool [8];
    div_op_t     op;
    logic [31:0] a, b;
    int          lat;

    nrst = 1'b0; req_valid = 1'b0; flush = 1'b0; req_op = OP_DIV; rs1 = 32'd0; rs2 = 32'd0;
    nc_req_valid = 1'b0; nc_flush = 1'b0; nc_req_op = OP_DIV; nc_rs1 = 32'd0; nc_rs2 = 32'd0;
    dv_lat = 4;
    m_vld = 1'b0; m_sgn = 1'b0; m_fresh = 1'b0; m_a = 32'd0; m_b = 32'd0;

    #12;
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst result_valid", 64'(result_valid), 64'd0);
    chk("rst div_en", 64'(div_en), 64'd0);
    chk("rst div_a/b/sgn", {div_a, div_b[30:0], div_is_signed}, 64'd0);
    @(negedge clk); nrst = 1'b1;

    // cold miss then same-operand reuse
    do_req(OP_DIVU, 32'd100, 32'd7, 5, "t1 divu 100/7");
    do_req(OP_REMU, 32'd100, 32'd7, 5, "t2 remu 100/7");
    nc_req(OP_DIVU, 32'd100, 32'd7, 32'd14, "nc divu 100/7");
    nc_req(OP_REMU, 32'd100, 32'd7, 32'd2, "nc remu 100/7");
    @(negedge clk); nc_req_valid = 1'b0;

    // signed overflow and truncating signed division
    do_req(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 4, "t3 div ovf");
    do_req(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4, "t3 rem ovf");
    do_req(OP_DIV, 32'hFFFF_FFF9, 32'd2, 3, "t3 div -7/2");

    // divide by zero, then signedness mismatch forces a rerun
    do_req(OP_DIVU, 32'd10, 32'd0, 2, "t4 divu 10/0");
    do_req(OP_REMU, 32'd10, 32'd0, 2, "t4 remu 10/0");
    do_req(OP_DIV, 32'd10, 32'd0, 2, "t4 div 10/0");
    idle(1);

    // flush while busy, and flush coincident with div_ready
    do_flush(OP_DIVU, 32'd100, 32'd7, 6, 4, "t5 flush busy");
    do_req(OP_REMU, 32'd100, 32'd7, 6, "t5 remu after flush");
    idle(1);
    do_flush(OP_DIVU, 32'd55, 32'd5, 3, 5, "t5 flush at ready");
    do_req(OP_DIVU, 32'd55, 32'd5, 3, "t5 divu after flush");
    do_flush(OP_DIV, 32'd9, 32'd4, 3, 0, "t5 flush idle");
    do_req(OP_DIVU, 32'd55, 32'd5, 3, "t5 cache kept");

    // async reset mid-BUSY
    dv_lat = 6;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
    end
    @(negedge clk);
    req_valid = 1'b0; nrst = 1'b0;
    #1;
    chk("t6 rst stall", 64'(stall), 64'd0);
    chk("t6 rst div_en", 64'(div_en), 64'd0);
    chk("t6 rst div_a", 64'(div_a), 64'd0);
    chk("t6 rst div_b/sgn", {div_b, 31'd0, div_is_signed}, 64'd0);
    chk("t6 rst result", 64'(result), 64'd0);
    @(negedge clk); nrst = 1'b1;
    m_vld = 1'b0; m_fresh = 1'b0;
    do_req(OP_DIVU, 32'd100, 32'd7, 4, "t6 divu after rst");

    // random mixed ops from a small operand pool so hits recur
    pool[0] = 32'd0;          pool[1] = 32'd1;          pool[2] = 32'd7;
    pool[3] = 32'd100;        pool[4] = 32'hFFFF_FFF9;  pool[5] = 32'h8000_0000;
    pool[6] = 32'hFFFF_FFFF;
    for (int i = 0; i < 1000; i++) begin
      pool[7] = $urandom;
      op  = div_op_t'(2'($urandom_range(0, 3)));
      a   = pool[$urandom_range(0, 7)];
      b   = pool[$urandom_range(0, 7)];
      lat = $urandom_range(1, 8);
      if (!pred_hit(op, a, b) && $urandom_range(0, 5) == 0)
        do_flush(op, a, b, lat, $urandom_range(0, lat + 2), "rnd flush");
      else
        do_req(op, a, b, lat, "rnd req");
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
